// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM states and the buffered {pc, word} entry.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IF_RESET,
    IF_RUN,
    IF_FLUSH
  } ifetch_state_t;

  localparam logic [31:0] INST_NOP        = 32'h0;
  localparam logic [31:0] IMEM_WORD_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: synchronous FIFO with flush and keep-head.
// Flush may keep the entry that becomes head after this cycle's pop.
module ifetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  input  logic             keep_head,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW-1:0]    rd_n, wr_b, wr_n;
  logic [CW-1:0]    cnt_b, cnt_n;
  logic             pop_ok, push_ok;

  assign head = mem[rd_ptr];

  // Pop first, then flush/keep, then push into the remaining space.
  always_comb begin
    pop_ok = pop && (count != '0);
    rd_n   = rd_ptr + AW'(pop_ok);
    cnt_b  = count - CW'(pop_ok);
    wr_b   = wr_ptr;
    if (flush) begin
      if (keep_head && (cnt_b != '0)) begin
        cnt_b = CW'(1);
        wr_b  = rd_n + AW'(1);
      end else begin
        cnt_b = '0;
        wr_b  = rd_n;
      end
    end
    push_ok = push && (cnt_b != CW'(DEPTH));
    wr_n    = wr_b + AW'(push_ok);
    cnt_n   = cnt_b + CW'(push_ok);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_n;
      wr_ptr <= wr_n;
      count  <= cnt_n;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_b] <= din;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues imem reads, buffers words.
// Define IFETCH_DELAY_SLOT_EN to keep the branch delay slot on redirect.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst_word,
  output logic        inst_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  ifetch_state_t state;
  logic [31:0]   fetch_pc, resp_pc, idle_pc;
  logic [CW-1:0] pending, squash, rem;
  logic [CW-1:0] fifo_count, cnt_after_pop;
  fetch_entry_t  din, head;
  logic          push, pop, flush, keep_head;
  logic          redir, rsp_ok, adv_resp, sq_dec;
`ifdef IFETCH_DELAY_SLOT_EN
  logic          keep_one;
  logic [31:0]   ds_pc;
`endif

  ifetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .din       (din),
    .pop       (pop),
    .flush     (flush),
    .keep_head (keep_head),
    .count     (fifo_count),
    .head      (head)
  );

  // Presentation, consume and request decisions for this cycle.
  always_comb begin
    inst_valid    = (fifo_count != '0);
    pc            = inst_valid ? head.pc : idle_pc;
    inst_word     = inst_valid ? head.word : INST_NOP;
    redir         = redirect && inst_valid && (state == IF_RUN);
    pop           = inst_valid && (!stall || redir);
    rsp_ok        = imem_rvalid && (pending != '0);
    rem           = pending - CW'(rsp_ok);
    cnt_after_pop = fifo_count - CW'(pop);
    imem_addr     = fetch_pc;
    imem_req      = (state == IF_RUN) && !redir &&
                    (({1'b0, pending} + {1'b0, cnt_after_pop}) < DEPTH_W);
  end

  // Response steering: push, squash, or keep the delay slot.
  always_comb begin
    push      = 1'b0;
    flush     = 1'b0;
    keep_head = 1'b0;
    adv_resp  = 1'b0;
    sq_dec    = 1'b0;
    din       = '{pc: resp_pc, word: imem_rdata};
    if (redir) begin
      flush = 1'b1;
`ifdef IFETCH_DELAY_SLOT_EN
      if (fifo_count > CW'(1)) begin
        keep_head = 1'b1;
      end else if (rsp_ok) begin
        push   = 1'b1;
        din.pc = head.pc + IMEM_WORD_BYTES;
      end
`endif
    end else if (rsp_ok) begin
`ifdef IFETCH_DELAY_SLOT_EN
      if (keep_one) begin
        push   = 1'b1;
        din.pc = ds_pc;
      end else
`endif
      if (squash != '0) begin
        sq_dec = 1'b1;
      end else begin
        push     = 1'b1;
        adv_resp = 1'b1;
      end
    end
  end

  // Fetch FSM plus PC, outstanding and squash counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IF_RESET;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      idle_pc  <= RESET_PC;
      pending  <= '0;
      squash   <= '0;
    end else begin
      pending <= pending + CW'(imem_req) - CW'(rsp_ok);
      if (imem_req) fetch_pc <= fetch_pc + IMEM_WORD_BYTES;
      if (adv_resp) resp_pc <= resp_pc + IMEM_WORD_BYTES;
      if (sq_dec) squash <= squash - CW'(1);
      if (pop) idle_pc <= head.pc + IMEM_WORD_BYTES;
      case (state)
        IF_RESET: state <= IF_RUN;
        IF_RUN: begin
          if (redir) begin
            state    <= IF_FLUSH;
            fetch_pc <= word_align(redirect_pc);
            resp_pc  <= word_align(redirect_pc);
            idle_pc  <= word_align(redirect_pc);
            squash   <= rem;
`ifdef IFETCH_DELAY_SLOT_EN
            if ((fifo_count <= CW'(1)) && !rsp_ok && (rem != '0))
              squash <= rem - CW'(1);
`endif
          end
        end
        IF_FLUSH: state <= IF_RUN;
        default:  state <= IF_RESET;
      endcase
    end
  end

`ifdef IFETCH_DELAY_SLOT_EN
  // Delay slot still in flight: remember to keep its response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      keep_one <= 1'b0;
      ds_pc    <= RESET_PC;
    end else if (redir) begin
      keep_one <= (fifo_count <= CW'(1)) && !rsp_ok && (rem != '0);
      ds_pc    <= head.pc + IMEM_WORD_BYTES;
    end else if (rsp_ok && keep_one) begin
      keep_one <= 1'b0;
    end
  end
`endif

endmodule
